// File: rtl/alu_writeback_queue.sv
// ---------------------------------------------------------------------------
// alu_writeback_queue
//
// Purpose:
//   Execute-to-writeback stage sitting directly behind the combinational ALU.
//   Each accepted ALU result that writes a register is pushed into a small
//   in-order queue. The queue drains into the register-file write port.
//   The block also holds the architectural carry flag that feeds the ALU
//   CarryIn, registers branch resolution as a one-cycle pulse, and offers
//   combinational forwarding of results that are queued but not yet written.
//
// Handshakes (both sides use strict valid/ready):
//   A transfer happens on a rising Clk edge only when valid and ready are
//   both high in that cycle. A producer holding valid=1 keeps its payload
//   stable until the transfer. Ready never depends combinationally on the
//   other side's valid.
//     Input side : accept = InValid & InReady.  InReady = (Count < DEPTH).
//     Output side: deq    = WbValid & WbReady.  WbValid = (Count != 0).
//   InReady comes from registered occupancy only. A dequeue in a full
//   cycle therefore re-opens the input one cycle later.
//
// Parameters:
//   DEPTH   number of queue entries (>= 1); pointers wrap modulo DEPTH
//   DATA_W  result/data width
//   ADDR_W  register-file address width
//
// Ports:
//   Clk, Reset                 rising-edge clock, async active-high reset
//   InValid/InReady            ALU result handshake
//   AluOut, CarryOut           ALU result and carry/shift-out
//   DestAddr, RegWrEn          destination register and write enable
//   CarryWrEn                  update the carry flag from CarryOut
//   IsBranch, BranchTarget     branch compare (AluOut[0] = condition), target
//   CarryFlag                  architectural carry, drives ALU CarryIn
//   BranchTaken, BranchPc      registered one-cycle branch pulse and target
//   WbValid/WbReady            register-file write handshake
//   WbAddr, WbData             head entry address and data
//   LookupAddr, FwdHit,FwdData forwarding lookup (youngest match wins)
//   Count                      queue occupancy
// ---------------------------------------------------------------------------
module alu_writeback_queue #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                       Clk,
    input  logic                       Reset,

    input  logic                       InValid,
    output logic                       InReady,
    input  logic [DATA_W-1:0]          AluOut,
    input  logic                       CarryOut,
    input  logic [ADDR_W-1:0]          DestAddr,
    input  logic                       RegWrEn,
    input  logic                       CarryWrEn,
    input  logic                       IsBranch,
    input  logic [7:0]                 BranchTarget,

    output logic                       CarryFlag,
    output logic                       BranchTaken,
    output logic [7:0]                 BranchPc,

    output logic                       WbValid,
    input  logic                       WbReady,
    output logic [ADDR_W-1:0]          WbAddr,
    output logic [DATA_W-1:0]          WbData,

    input  logic [ADDR_W-1:0]          LookupAddr,
    output logic                       FwdHit,
    output logic [DATA_W-1:0]          FwdData,

    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    // A single-entry queue still needs a one-bit pointer to index storage.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [PTR_W-1:0]  head_q,     head_d;
    logic [PTR_W-1:0]  tail_q,     tail_d;
    logic              carry_q,    carry_d;
    logic              br_taken_q, br_taken_d;
    logic [7:0]        br_pc_q,    br_pc_d;

    // Entry storage has no reset. Only entries covered by count_q are ever
    // observed, so stale contents are harmless.
    logic [ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    logic in_ready;
    logic wb_valid;
    logic accept;
    logic deq;
    logic enq;
    logic branch_acc;
    logic carry_upd;

    assign in_ready   = (count_q < CNT_W'(DEPTH));
    assign wb_valid   = (count_q != '0);
    assign accept     = InValid & in_ready;
    assign deq        = wb_valid & WbReady;
    // Branches never write a register, even when RegWrEn is set.
    assign enq        = accept & RegWrEn & ~IsBranch;
    assign branch_acc = accept & IsBranch;
    assign carry_upd  = accept & CarryWrEn & ~IsBranch;

    // Pointer advance with wrap at DEPTH. This also works for DEPTH values
    // that are not a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = p + PTR_W'(1);
        end
    endfunction

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        carry_d    = carry_q;
        br_taken_d = 1'b0;
        br_pc_d    = br_pc_q;

        if (enq) begin
            tail_d = next_ptr(tail_q);
        end
        if (deq) begin
            head_d = next_ptr(head_q);
        end

        // A simultaneous enqueue and dequeue leaves the occupancy unchanged.
        // Enqueue requires Count < DEPTH, so the increment cannot overflow.
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (carry_upd) begin
            carry_d = CarryOut;
        end

        // BranchTaken defaults to 0, so it can only ever be a single-cycle
        // pulse. BranchPc keeps the last taken target.
        if (branch_acc) begin
            br_taken_d = AluOut[0];
            if (AluOut[0]) begin
                br_pc_d = BranchTarget;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control registers (async reset discards queued entries)
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            carry_q    <= 1'b0;
            br_taken_q <= 1'b0;
            br_pc_q    <= '0;
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            carry_q    <= carry_d;
            br_taken_q <= br_taken_d;
            br_pc_q    <= br_pc_d;
        end
    end

    // -----------------------------------------------------------------------
    // Entry storage
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (enq) begin
            mem_addr_q[tail_q] <= DestAddr;
            mem_data_q[tail_q] <= AluOut;
        end
    end

    // -----------------------------------------------------------------------
    // Forwarding: walk the valid entries from oldest to youngest so that the
    // last match, which is the youngest, wins. The head entry still counts
    // in the cycle it is being dequeued, because count_q has not dropped yet.
    // -----------------------------------------------------------------------
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    always_comb begin
        int               idx;
        logic [PTR_W-1:0] slot;

        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = 0;
        slot     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = int'(head_q) + i;
            if (idx >= DEPTH) begin
                idx = idx - DEPTH;
            end
            slot = PTR_W'(idx);
            if ((i < int'(count_q)) && (mem_addr_q[slot] == LookupAddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data_q[slot];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign InReady     = in_ready;
    assign WbValid     = wb_valid;
    assign WbAddr      = mem_addr_q[head_q];
    assign WbData      = mem_data_q[head_q];
    assign FwdHit      = fwd_hit;
    assign FwdData     = fwd_data;
    assign Count       = count_q;
    assign CarryFlag   = carry_q;
    assign BranchTaken = br_taken_q;
    assign BranchPc    = br_pc_q;

endmodule

// File: doc/alu_writeback_queue.md
Name: alu_writeback_queue

Overview:
Execute-to-writeback stage directly downstream of the combinational ALU. It captures each ALU result into a small in-order queue that drains into the register-file write port under a valid/ready handshake. It owns the architectural carry flag, which feeds the ALU CarryIn. It registers branch resolution from the ALU compare result, and provides combinational forwarding of not-yet-written results.

Parameters:
DEPTH, 2, number of queue entries (>=1); pointers wrap modulo DEPTH
DATA_W, 8, result/data width
ADDR_W, 3, register-file address width

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
InValid  in  1  ALU result valid this cycle
InReady  out  1  stage can accept; = (Count < DEPTH)
AluOut  in  DATA_W  ALU result
CarryOut  in  1  ALU carry/shift-out
DestAddr  in  ADDR_W  destination register
RegWrEn  in  1  result is to be written to DestAddr
CarryWrEn  in  1  update carry flag from CarryOut
IsBranch  in  1  op is a branch compare; AluOut[0] = condition
BranchTarget  in  8  target PC for the branch
CarryFlag  out  1  architectural carry, drives ALU CarryIn
BranchTaken  out  1  one-cycle pulse, registered
BranchPc  out  8  registered target, valid while BranchTaken=1
WbValid  out  1  head entry present; = (Count != 0)
WbReady  in  1  register file accepts write
WbAddr  out  ADDR_W  head entry address
WbData  out  DATA_W  head entry data
LookupAddr  in  ADDR_W  forwarding lookup address
FwdHit  out  1  some queued entry targets LookupAddr
FwdData  out  DATA_W  data of youngest matching entry
Count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- accept = InValid & InReady. deq = WbValid & WbReady. All state updates occur on the rising Clk edge.
- Reset asserted (any time, async): Count=0, head/tail ptr=0, CarryFlag=0, BranchTaken=0, BranchPc=0. Queued entries are discarded with no write issued. WbValid=0 and FwdHit=0 immediately.
- Enqueue: accept & RegWrEn & !IsBranch -> write {DestAddr, AluOut} at tail, tail = (tail+1) mod DEPTH.
- Ops with RegWrEn=0 (carry-only, branch, no-op) still consume the handshake but do not enqueue.
- Dequeue: deq -> head = (head+1) mod DEPTH. WbAddr/WbData are combinational from the head entry and hold stable while WbValid=1 & WbReady=0.
- Count: +1 on enqueue only; -1 on dequeue only; unchanged on simultaneous enqueue+dequeue. Simultaneous enqueue+dequeue is possible only when Count < DEPTH.
- Full (Count==DEPTH): InReady=0. A dequeue that cycle does not raise InReady until the next cycle (no combinational ready path).
- Empty: WbValid=0, and WbData/WbAddr are don't-care.
- Carry: accept & CarryWrEn & !IsBranch -> CarryFlag <= CarryOut, visible to the ALU the next cycle. Otherwise CarryFlag holds.
- Branch: accept & IsBranch -> BranchTaken <= AluOut[0], and BranchPc <= BranchTarget if AluOut[0]. In every other cycle BranchTaken <= 0, so it is a 1-cycle pulse. RegWrEn and CarryWrEn are ignored on branches.
- Forwarding is combinational over valid entries only. The youngest matching entry wins. An entry being dequeued in the current cycle still counts. The in-flight input is not considered.
- No latency from CarryOut to CarryFlag beyond 1 cycle. Enqueue-to-WbValid latency is 1 cycle.

Test Plan:
- Reset mid-operation: enqueue two writes (r1=0x11, r2=0x22), WbReady=0, pulse Reset -> Count=0, WbValid=0, FwdHit=0, CarryFlag=0 immediately. No write ever appears.
- Fill/stall: WbReady=0, enqueue r3=0xA5, r4=0x5A -> Count=2, InReady=0, WbAddr=3, WbData=0xA5 held. Raise WbReady -> drains 0xA5 then 0x5A in order, Count reaches 0.
- Simultaneous: Count=1 (r1=0x01), WbReady=1, enqueue r2=0x02 same cycle -> Count stays 1, next head is r2/0x02.
- Wrap-around: stream 5 writes (values 0x10..0x14) with WbReady toggling 1/0 -> register file receives exactly 0x10..0x14 in order.
- Forwarding: queue r5=0x33 then r5=0x44, LookupAddr=5 -> FwdHit=1, FwdData=0x44. LookupAddr=6 -> FwdHit=0.
- Carry/branch: CarryWrEn=1, CarryOut=1 -> CarryFlag=1 next cycle. IsBranch=1, AluOut=0x01, BranchTarget=0x3C -> BranchTaken=1, BranchPc=0x3C for exactly one cycle. AluOut=0x00 -> BranchTaken stays 0, CarryFlag unchanged.
